// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the master side; the byte source / memory model takes the slave side.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        RW;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, IAddr, IDataIn, RW
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, IAddr, IDataIn, RW
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: packs a byte stream little-endian into
// 32-bit words and writes them to consecutive word addresses from BASE_ADDR.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd8,
  parameter int          MAX_WORDS = 175
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [7:0]          num_words,
  imem_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          words_written
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    RELEASE,
    FINISH
  } state_e;

  localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] idata_q, idata_d;
  logic        err_q, err_d;
  logic [7:0]  words_q, words_d;
  logic        rw_q, rw_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    err_d   = err_q;
    words_d = words_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          words_d = 8'd0;
          iaddr_d = BASE_ADDR;
          n_d     = num_words;
          k_d     = 2'd0;
          if ({1'b0, num_words} > MAX_W) begin
            err_d = 1'b1;
          end else if (num_words == 8'd0) begin
            state_d = FINISH;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.byte_valid && ready_q) begin
          idata_d[{k_q, 3'b000} +: 8] = bus.byte_in;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        words_d = words_q + 8'd1;
        state_d = RELEASE;
      end
      RELEASE: begin
        // words_q already includes the word just written.
        if (words_q == n_q) begin
          state_d = FINISH;
        end else begin
          iaddr_d = iaddr_q + 32'd4;
          k_d     = 2'd0;
          state_d = COLLECT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in the state they describe.
    rw_d    = (state_d == WRITE);
    ready_d = (state_d == COLLECT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      n_q     <= 8'd0;
      iaddr_q <= BASE_ADDR;
      idata_q <= 32'd0;
      err_q   <= 1'b0;
      words_q <= 8'd0;
      rw_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      err_q   <= err_d;
      words_q <= words_d;
      rw_q    <= rw_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.IAddr      = iaddr_q;
  assign bus.IDataIn    = idata_q;
  assign bus.RW         = rw_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_written  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as words are
// driven and popped by a monitor that watches every RW pulse.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       CLK;
  logic       RST;
  logic       start;
  logic [7:0] num_words;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] words_written;

  imem_loader_if bus_if ();

  imem_loader #(
    .BASE_ADDR (32'd8),
    .MAX_WORDS (175)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .num_words     (num_words),
    .bus           (bus_if),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  int  vectors    = 0;
  int  miscompares = 0;
  int  cyc        = 0;
  int  start_cyc  = 0;
  int  rw_count   = 0;
  int  done_count = 0;
  wr_t exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every RW pulse must match the oldest queued write, and the
  // following cycle must keep address/data stable with byte_ready low.
  logic        prev_rw = 1'b0;
  logic [31:0] held_addr, held_data;
  always @(negedge CLK) begin
    if (bus_if.RW === 1'b1) begin
      rw_count++;
      check("byte_ready_in_write", {31'd0, bus_if.byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rw_addr", bus_if.IAddr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus_if.IAddr, e.addr);
        check("wr_data", bus_if.IDataIn, e.data);
      end
      held_addr = bus_if.IAddr;
      held_data = bus_if.IDataIn;
    end else if (prev_rw && !RST) begin
      check("release_ready", {31'd0, bus_if.byte_ready}, 32'd0);
      check("release_addr", bus_if.IAddr, held_addr);
      check("release_data", bus_if.IDataIn, held_data);
    end
    prev_rw = (bus_if.RW === 1'b1);
    if (done === 1'b1) done_count++;
  end

  task automatic do_start(input logic [7:0] n);
    start     = 1'b1;
    num_words = n;
    start_cyc = cyc;
    @(negedge CLK);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    bus_if.byte_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_in    = b;
    waited = 0;
    while (bus_if.byte_ready !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    check("byte_ready_wait", {31'd0, bus_if.byte_ready}, 32'd1);
    @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int max_gap);
    exp_q.push_back('{addr: addr, data: w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
    bus_if.byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iaddr"}, bus_if.IAddr, 32'd8);
    check({tag, "_idata"}, bus_if.IDataIn, 32'd0);
    check({tag, "_rw"}, {31'd0, bus_if.RW}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus_if.byte_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_words"}, {24'd0, words_written}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int          rw0;
    int          dc0;
    logic [31:0] w;
    logic [31:0] w1, w2;

    RST = 1'b1;
    start = 1'b0;
    num_words = 8'd0;
    bus_if.byte_valid = 1'b0;
    bus_if.byte_in = 8'd0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Single word, continuous stream: 4 bytes + WRITE + RELEASE, done 7 cycles after start.
    rw0 = rw_count;
    do_start(8'd1);
    check("n1_ready_t1", {31'd0, bus_if.byte_ready}, 32'd1);
    check("n1_busy_t1", {31'd0, busy}, 32'd1);
    send_word(32'd8, 32'hE000_0002, 0);
    wait_done(20);
    check("n1_latency", cyc - start_cyc, 32'd7);
    check("n1_words", {24'd0, words_written}, 32'd1);
    check("n1_rw_pulses", rw_count - rw0, 32'd1);
    @(negedge CLK);
    check("n1_idle_busy", {31'd0, busy}, 32'd0);
    check("n1_final_addr", bus_if.IAddr, 32'd8);
    check("n1_final_data", bus_if.IDataIn, 32'hE000_0002);

    // Three words with random gaps between bytes.
    rw0 = rw_count;
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      send_word(32'd8 + 32'(4 * i), w, 3);
    end
    wait_done(100);
    check("n3_words", {24'd0, words_written}, 32'd3);
    check("n3_rw_pulses", rw_count - rw0, 32'd3);
    check("n3_final_addr", bus_if.IAddr, 32'd16);

    // Zero-length load finishes immediately.
    @(negedge CLK);
    rw0 = rw_count;
    do_start(8'd0);
    check("n0_done_t1", {31'd0, done}, 32'd1);
    check("n0_err", {31'd0, err}, 32'd0);
    check("n0_words", {24'd0, words_written}, 32'd0);
    repeat (3) @(negedge CLK);
    check("n0_rw_pulses", rw_count - rw0, 32'd0);

    // Over-length request sets err and never leaves IDLE.
    rw0 = rw_count;
    dc0 = done_count;
    do_start(8'd200);
    check("n200_err_t1", {31'd0, err}, 32'd1);
    check("n200_busy_t1", {31'd0, busy}, 32'd0);
    bus_if.byte_valid = 1'b1;
    bus_if.byte_in = 8'hAA;
    repeat (4) @(negedge CLK);
    bus_if.byte_valid = 1'b0;
    check("n200_busy_later", {31'd0, busy}, 32'd0);
    check("n200_err_sticky", {31'd0, err}, 32'd1);
    check("n200_rw_pulses", rw_count - rw0, 32'd0);
    check("n200_no_done", done_count - dc0, 32'd0);

    // A following valid load clears err and completes.
    do_start(8'd1);
    check("after_err_cleared", {31'd0, err}, 32'd0);
    send_word(32'd8, 32'h1234_5678, 1);
    wait_done(30);
    check("after_err_words", {24'd0, words_written}, 32'd1);
    @(negedge CLK);

    // Reset after two bytes of word 2 discards the partial word.
    do_start(8'd3);
    send_word(32'd8, 32'hCAFE_F00D, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    bus_if.byte_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;
    @(negedge CLK);
    rw0 = rw_count;
    do_start(8'd1);
    send_word(32'd8, 32'h8765_4321, 2);
    wait_done(40);
    check("postrst_rw_pulses", rw_count - rw0, 32'd1);
    check("postrst_data", bus_if.IDataIn, 32'h8765_4321);
    @(negedge CLK);

    // start while busy, with a different length, must be ignored.
    rw0 = rw_count;
    w1 = 32'hA1B2_C3D4;
    w2 = 32'h0F1E_2D3C;
    do_start(8'd2);
    exp_q.push_back('{addr: 32'd8, data: w1});
    send_byte(w1[7:0], 0);
    start = 1'b1;
    num_words = 8'd5;
    send_byte(w1[15:8], 0);
    start = 1'b0;
    send_byte(w1[23:16], 0);
    send_byte(w1[31:24], 0);
    bus_if.byte_valid = 1'b0;
    send_word(32'd12, w2, 0);
    wait_done(60);
    check("busy_start_words", {24'd0, words_written}, 32'd2);
    check("busy_start_rw_pulses", rw_count - rw0, 32'd2);
    repeat (3) @(negedge CLK);
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
